// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, datapath
// select encodings, the control FSM states and the per-state control word.
package cpu_defs;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_WB_I     = 4'd9,
        ST_WB_MEM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

    // Moore part of the control outputs; ir_write and the FETCH pc_write are
    // gated by mem_ready in the top and are not part of this word.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PC_SRC_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_RTYPE;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_WB_I: c.reg_write = 1'b1;
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles in a wait state and flags the cycle in which the
// wait budget runs out without mem_ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    localparam logic [3:0] LAST = 4'(MEM_TIMEOUT - 1);

    logic [3:0] count;

    // mem_ready on the final budget cycle still completes the access.
    assign expired = active && !mem_ready && (count == LAST);

    // Held at zero outside wait states, so every entry starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || mem_ready || expired) begin
            count <= '0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/
// memory/write-back and drives every datapath select and write enable.
module multicycle_ctrl
    import cpu_defs::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALU_OP,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output state_t     dbg_state
);

    // Memory handshake: a request (mem_read/mem_write) is held for as long as
    // the FSM sits in a wait state; a cycle with mem_ready=1 in that state
    // completes it. mem_ready in any other state has no effect.
    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   wait_active;
    logic   expired;
    logic   fetch_done;
    logic   decode_bad;

    assign wait_active = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
    assign fetch_done  = (state == ST_FETCH) && mem_ready;
    assign decode_bad  = (state == ST_DECODE) && (next_state == ST_FETCH);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (wait_active),
        .mem_ready(mem_ready),
        .expired  (expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = ST_FETCH;
            ST_FETCH: if (mem_ready) next_state = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_R:         next_state = ST_EXEC_R;
                    OP_ADDIU:     next_state = ST_EXEC_I;
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_EXEC_R:   next_state = ST_WB_R;
            ST_EXEC_I:   next_state = ST_WB_I;
            ST_MEM_ADDR: next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready) next_state = ST_WB_MEM;
                else if (expired) next_state = ST_FETCH;
            end
            ST_MEM_WR: if (mem_ready || expired) next_state = ST_FETCH;
            default: next_state = ST_FETCH;
        endcase
    end

    // Outputs are registered from next_state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ctrl    <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= next_state;
            ctrl    <= ctrl_of(next_state);
            illegal <= expired || decode_bad;
        end
    end

    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = fetch_done;
    assign pc_write      = ctrl.pc_write | fetch_done;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign ALU_OP        = ctrl.alu_op;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign dbg_state     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands
// each instruction into expected per-cycle states and control outputs.
module tb_multicycle_ctrl;
    import cpu_defs::*;

    localparam int TMO = 15;
    localparam int W   = 21;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, ALU_OP;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
    state_t     dbg_state;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALU_OP(ALU_OP),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   stim_q[$];
    logic [5:0]   cur_op = '0;
    logic         pend_ill = 1'b0;
    logic         zero_rand = 1'b1;
    logic         zero_fix = 1'b0;

    logic [W-1:0] obs;
    assign obs = {dbg_state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                  pc_source, alu_src_a, alu_src_b, ALU_OP, reg_write, reg_dst, mem_to_reg, illegal};

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] expect_word(state_t s, logic done, logic ill);
        logic mr = 0, mw = 0, iod = 0, irw = 0, pcw = 0, pcc = 0, srca = 0;
        logic rw = 0, rd = 0, m2r = 0;
        logic [1:0] pcs = 0, srcb = 0, aop = 0;
        case (s)
            ST_FETCH:    begin mr = 1; srcb = 2'b01; irw = done; pcw = done; end
            ST_DECODE:   srcb = 2'b11;
            ST_EXEC_R:   begin srca = 1; aop = 2'b10; end
            ST_EXEC_I:   begin srca = 1; srcb = 2'b10; end
            ST_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
            ST_MEM_RD:   begin mr = 1; iod = 1; end
            ST_MEM_WR:   begin mw = 1; iod = 1; end
            ST_WB_R:     begin rw = 1; rd = 1; end
            ST_WB_I:     rw = 1;
            ST_WB_MEM:   begin rw = 1; m2r = 1; end
            ST_BRANCH:   begin srca = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            ST_JUMP:     begin pcw = 1; pcs = 2'b10; end
            default:     ;
        endcase
        return {s, mr, mw, iod, irw, pcw, pcc, pcs, srca, srcb, aop, rw, rd, m2r, ill};
    endfunction

    function automatic void model_cycle(state_t s, logic rdy, logic done);
        logic z;
        z = zero_rand ? 1'($urandom_range(0, 1)) : zero_fix;
        stim_q.push_back({cur_op, rdy, z});
        exp_q.push_back(expect_word(s, done, pend_ill));
        pend_ill = 1'b0;
    endfunction

    // Cycles where mem_ready must be ignored get a random value.
    function automatic void model_step(state_t s);
        model_cycle(s, 1'($urandom_range(0, 1)), 1'b0);
    endfunction

    // A memory access that sees 'waits' not-ready cycles; returns 0 on timeout.
    function automatic logic model_access(state_t s, int waits);
        int n;
        n = (waits < TMO) ? waits : TMO;
        for (int i = 0; i < n; i++) model_cycle(s, 1'b0, 1'b0);
        if (waits >= TMO) begin
            pend_ill = 1'b1;
            return 1'b0;
        end
        model_cycle(s, 1'b1, 1'b1);
        return 1'b1;
    endfunction

    function automatic void model_instr(logic [5:0] op, int fwait, int mwait);
        if (!model_access(ST_FETCH, fwait)) void'(model_access(ST_FETCH, 0));
        cur_op = op;
        model_step(ST_DECODE);
        case (op)
            OP_R:     begin model_step(ST_EXEC_R); model_step(ST_WB_R); end
            OP_ADDIU: begin model_step(ST_EXEC_I); model_step(ST_WB_I); end
            OP_LW: begin
                model_step(ST_MEM_ADDR);
                if (model_access(ST_MEM_RD, mwait)) model_step(ST_WB_MEM);
            end
            OP_SW: begin
                model_step(ST_MEM_ADDR);
                void'(model_access(ST_MEM_WR, mwait));
            end
            OP_BEQ:   model_step(ST_BRANCH);
            OP_J:     model_step(ST_JUMP);
            default:  pend_ill = 1'b1;
        endcase
    endfunction

    function automatic void model_tail();
        model_cycle(ST_FETCH, 1'b0, 1'b0);
        model_cycle(ST_FETCH, 1'b0, 1'b0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur_op = '0;
        pend_ill = 1'b0;
        zero_rand = 1'b1;
        exp_q.delete();
        stim_q.delete();
    endtask

    task automatic drive_cycle(input logic [7:0] s, output logic [W-1:0] o);
        {opcode, mem_ready, zero} = s;
        #1;
        o = obs;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] e;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = OP_J;
        #1;
        e = expect_word(ST_IDLE, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_assert got=%h exp=%h", obs, e);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (dbg_state !== ST_IDLE || ir_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got=%0d ir_write=%b exp=%0d", dbg_state, ir_write, ST_IDLE);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        e = expect_word(ST_FETCH, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_first_fetch got=%h exp=%h", obs, e);
        end
        @(negedge clk);
    endtask

    task automatic test_r_type();
        logic [W-1:0] o, e;
        int cyc = 0;
        apply_reset();
        model_step(ST_IDLE);
        model_instr(OP_R, 0, 0);
        model_instr(OP_ADDIU, 2, 0);
        model_tail();
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL r_type cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_lw_wait();
        logic [W-1:0] o, e;
        int cyc = 0;
        int rd_cycles = 0;
        apply_reset();
        model_step(ST_IDLE);
        model_instr(OP_LW, 0, 3);
        model_instr(OP_SW, 1, 0);
        model_tail();
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            if (o[16] && o[14]) rd_cycles++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lw_wait cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
        checks++;
        if (rd_cycles != 4) begin
            errors++;
            $display("FAIL lw_read_hold got=%0d exp=4", rd_cycles);
        end
    endtask

    task automatic test_beq();
        logic [W-1:0] o, e;
        int cyc = 0;
        for (int z = 1; z >= 0; z--) begin
            apply_reset();
            zero_rand = 1'b0;
            zero_fix = 1'(z);
            model_step(ST_IDLE);
            model_instr(OP_BEQ, 0, 0);
            model_instr(OP_J, 0, 0);
            model_tail();
            while (stim_q.size() > 0) begin
                drive_cycle(stim_q.pop_front(), o);
                e = exp_q.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL beq_zero%0d cyc=%0d got=%h exp=%h", z, cyc, o, e);
                end
                cyc++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] o, e;
        int cyc = 0;
        int pulses = 0;
        apply_reset();
        model_step(ST_IDLE);
        model_instr(6'b111111, 0, 0);
        model_tail();
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            pulses += int'(o[0]);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL illegal_op cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL illegal_pulse_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] o, e;
        int cyc = 0;
        int pulses = 0;
        apply_reset();
        model_step(ST_IDLE);
        model_instr(OP_SW, 0, TMO);
        model_instr(OP_SW, 0, TMO - 1);
        model_instr(OP_LW, 0, TMO);
        model_instr(OP_R, TMO, 0);
        model_tail();
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            pulses += int'(o[0]);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL timeout_pulse_count got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] o, e;
        logic [5:0] ops[7];
        logic [5:0] op;
        int cyc = 0;
        int fw, mw;
        ops = '{OP_R, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J, 6'b111111};
        apply_reset();
        model_step(ST_IDLE);
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
            fw = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0:       mw = TMO;
                1:       mw = TMO - 1;
                default: mw = $urandom_range(0, 4);
            endcase
            model_instr(op, fw, mw);
        end
        model_tail();
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] o, e;
        int cyc = 0;
        apply_reset();
        model_step(ST_IDLE);
        void'(model_access(ST_FETCH, 0));
        cur_op = OP_SW;
        model_step(ST_DECODE);
        model_step(ST_MEM_ADDR);
        model_cycle(ST_MEM_WR, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mem_write got=%b exp=1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        e = expect_word(ST_IDLE, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid_async got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid_idle got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        #1;
        e = expect_word(ST_FETCH, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid_fetch_wait got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        e = expect_word(ST_FETCH, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid_fetch_done got=%h exp=%h", obs, e);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
